quant_drain_ctrl: RTL and testbench
===================================

Name: quant_drain_ctrl

Overview:
- Sequences the drain of one accumulator vector (N lanes, ACC_WIDTH each) from the array into a DATA_WIDTH output stream.
- Captures the vector on a start handshake, then emits one lane per beat on a valid/ready stream.
- Each lane is rounded, arithmetically right-shifted and saturated to signed DATA_WIDTH.
- Sits between the accumulator bank and the activation writeback / output FIFO.

Parameters:
- N, `N, number of accumulator lanes per job.
- DATA_WIDTH, `DATA_WIDTH, signed output element width.
- ACC_WIDTH, DATA_WIDTH*2+$clog2(N), signed accumulator lane width.
- SHIFT_WIDTH, $clog2(ACC_WIDTH), width of the requantization shift amount.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  job request; vector and shift are valid.
- in_ready  output  1  controller can accept a job (IDLE only).
- in_acc  input  N*ACC_WIDTH  packed signed lanes; lane i = in_acc[i*ACC_WIDTH +: ACC_WIDTH].
- in_shift  input  SHIFT_WIDTH  right-shift amount for this job.
- out_data  output  DATA_WIDTH  signed quantized element, registered.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts the beat.
- out_last  output  1  current beat is lane N-1.
- busy  output  1  job in progress (STREAM or DONE).
- done  output  1  one-cycle pulse after the last beat is accepted.
- sat_count  output  $clog2(N+1)  number of saturated lanes in the current/last job.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, idx=0.
  - out_valid=0, out_last=0, out_data=0, done=0, busy=0, sat_count=0, in_ready=1 after the edge.
  - Applies mid-stream: the job is abandoned and no further beats or done pulse are produced.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready:
    - Latch in_acc into the lane regs and in_shift into the shift reg.
    - Clamp the shift: if in_shift>ACC_WIDTH-1, use ACC_WIDTH-1.
    - Load out_data with quantized lane 0, computed directly from the in_acc/in_shift inputs.
    - Set out_valid=1; set out_last=1 if N==1; set sat_count to lane 0's saturation flag; idx=0.
    - Go to STREAM. First beat is valid the cycle after the accepting edge.
  - STREAM: out_valid=1, busy=1, in_valid ignored.
    - On out_valid&&out_ready with idx<N-1: idx++, load out_data with lane idx+1, sat_count += that lane's flag, out_last=(idx+1==N-1).
    - On the handshake with idx==N-1: out_valid=0, out_last=0, go to DONE.
    - No handshake: out_data, out_last and idx hold exactly.
  - DONE: done=1 for exactly this cycle, busy=1, in_ready=0. Unconditionally return to IDLE. sat_count holds until the next capture.
- Quantize (combinational, one instance, shared across lanes by a mux on idx):
  - Rounding term r = (s==0) ? 0 : 1<<(s-1), where s is the clamped shift.
  - t = (sign-extend acc to ACC_WIDTH+1) + r, computed in ACC_WIDTH+1 bits so there is no overflow.
  - q = t >>> s (arithmetic shift).
  - If q > 2^(DATA_WIDTH-1)-1: out = MAX, sat flag=1.
  - If q < -2^(DATA_WIDTH-1): out = MIN, sat flag=1.
  - Otherwise out = q[DATA_WIDTH-1:0], sat flag=0.
  - Net effect: round half toward +inf, then saturate.
- Throughput: N beats in N cycles with out_ready held high. A job occupies N+1 cycles from the accepting edge to the done pulse. The next job can be accepted the cycle after done.
- out_valid never drops while a beat is pending (AXI-style stability). in_ready is purely a state decode.

Test Plan (N=4, DATA_WIDTH=8, ACC_WIDTH=18, out_ready=1 unless stated):
- shift=0, lanes {5,-3,127,-128} -> beats 5,-3,127,-128 on consecutive cycles; out_last on beat 4; done pulse the next cycle; sat_count=0.
- shift=0, lanes {200,-300,131071,-131072} -> beats 127,-128,127,-128; sat_count=4.
- shift=2, lanes {6,-6,5,-5} -> beats 2,-1,1,-1; in_shift=31 is clamped to 17, so lanes {131071,...} -> 1.
- Backpressure: drop out_ready for 3 cycles after beat 1 -> out_data stays at beat 2's value, out_valid stays 1, idx unchanged; the stream then resumes with no lost or duplicated beats.
- in_valid held high through STREAM and DONE with different data -> ignored (in_ready=0); the new job is captured only in the first IDLE cycle after done.
- Assert rst during beat 3 -> next cycle out_valid=0, busy=0, in_ready=1, sat_count=0, no done pulse; a fresh job then runs normally.

Source files
------------

// File: rtl/quant_drain_ctrl.sv
// Drains one captured accumulator vector as a valid/ready stream of
// rounded, shifted and saturated signed elements, one lane per beat.
module quant_drain_ctrl #(
  parameter int N           = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = DATA_WIDTH * 2 + $clog2(N),
  parameter int SHIFT_WIDTH = $clog2(ACC_WIDTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N*ACC_WIDTH-1:0]        in_acc,
  input  logic [SHIFT_WIDTH-1:0]        in_shift,
  output logic signed [DATA_WIDTH-1:0]  out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(N+1)-1:0]        sat_count
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(N + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic [IDX_W-1:0]       LAST_IDX  = IDX_W'(N - 1);
  localparam logic [SHIFT_WIDTH-1:0] SHIFT_MAX = SHIFT_WIDTH'(ACC_WIDTH - 1);

  localparam logic signed [ACC_WIDTH:0] Q_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] Q_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  // Round half toward +inf, arithmetic shift, then saturate; MSB of the
  // result is the saturation flag. One extra bit keeps the rounding add exact.
  function automatic logic [DATA_WIDTH:0] quantize(
    input logic signed [ACC_WIDTH-1:0]  acc,
    input logic        [SHIFT_WIDTH-1:0] s
  );
    logic signed [ACC_WIDTH:0] r;
    logic signed [ACC_WIDTH:0] t;
    logic signed [ACC_WIDTH:0] q;
    r = '0;
    if (s != '0) r = (ACC_WIDTH+1)'(1) << (s - SHIFT_WIDTH'(1));
    t = {acc[ACC_WIDTH-1], acc} + r;
    q = t >>> s;
    if (q > Q_MAX)      quantize = {1'b1, 1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (q < Q_MIN) quantize = {1'b1, 1'b1, {(DATA_WIDTH-1){1'b0}}};
    else                quantize = {1'b0, q[DATA_WIDTH-1:0]};
  endfunction

  logic [1:0]                   state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d, nxt_idx;
  logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                         out_valid_q, out_valid_d;
  logic                         out_last_q, out_last_d;
  logic [CNT_W-1:0]             sat_count_q, sat_count_d;
  logic [N*ACC_WIDTH-1:0]       acc_q, acc_d;
  logic [SHIFT_WIDTH-1:0]       shift_q, shift_d, shift_clamp;

  logic signed [ACC_WIDTH-1:0]  q_acc;
  logic [SHIFT_WIDTH-1:0]       q_shift;
  logic signed [DATA_WIDTH-1:0] q_data;
  logic                         q_sat;

  assign shift_clamp = (in_shift > SHIFT_MAX) ? SHIFT_MAX : in_shift;
  assign nxt_idx     = (idx_q == LAST_IDX) ? idx_q : idx_q + IDX_W'(1);

  // The single quantizer sees the live inputs while idle and the next
  // captured lane while streaming.
  always_comb begin
    q_acc   = acc_q[nxt_idx*ACC_WIDTH +: ACC_WIDTH];
    q_shift = shift_q;
    if (state_q == IDLE) begin
      q_acc   = in_acc[ACC_WIDTH-1:0];
      q_shift = shift_clamp;
    end
    {q_sat, q_data} = quantize(q_acc, q_shift);
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    sat_count_d = sat_count_q;
    acc_d       = acc_q;
    shift_d     = shift_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d       = in_acc;
          shift_d     = shift_clamp;
          out_data_d  = q_data;
          out_valid_d = 1'b1;
          out_last_d  = (LAST_IDX == '0);
          sat_count_d = CNT_W'(q_sat);
          idx_d       = '0;
          state_d     = STREAM;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = DONE;
          end else begin
            idx_d       = nxt_idx;
            out_data_d  = q_data;
            sat_count_d = sat_count_q + CNT_W'(q_sat);
            out_last_d  = (nxt_idx == LAST_IDX);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      sat_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      sat_count_q <= sat_count_d;
    end
  end

  // Captured lanes and shift are pure data and need no reset.
  always_ff @(posedge clk) begin
    acc_q   <= acc_d;
    shift_q <= shift_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_quant_drain_ctrl.sv
// Directed, table-driven bench for quant_drain_ctrl (N=4, DATA_WIDTH=8).
module tb_quant_drain_ctrl;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 18;
  localparam int SW = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [N*AW-1:0]      in_acc;
  logic [SW-1:0]        in_shift;
  logic signed [DW-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic                 busy;
  logic                 done;
  logic [2:0]           sat_count;

  int n_vec  = 0;
  int n_fail = 0;

  quant_drain_ctrl #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .SHIFT_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_acc(in_acc), .in_shift(in_shift), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int l0, l1, l2, l3;
    int shift;
    int e0, e1, e2, e3;
    int sat;
  } vec_t;

  vec_t tbl[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input vec_t v);
    in_acc[0*AW +: AW] = AW'(v.l0);
    in_acc[1*AW +: AW] = AW'(v.l1);
    in_acc[2*AW +: AW] = AW'(v.l2);
    in_acc[3*AW +: AW] = AW'(v.l3);
    in_shift = SW'(v.shift);
  endtask

  task automatic run_job(input vec_t v, input string tag);
    int ex[4];
    ex[0] = v.e0; ex[1] = v.e1; ex[2] = v.e2; ex[3] = v.e3;
    check({tag, ".idle_ready"}, int'(in_ready), 1);
    load(v);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int b = 0; b < N; b++) begin
      if (b > 0) step();
      check($sformatf("%s.beat%0d", tag, b), int'(out_data), ex[b]);
      check($sformatf("%s.valid%0d", tag, b), int'(out_valid), 1);
      check($sformatf("%s.last%0d", tag, b), int'(out_last), (b == N-1) ? 1 : 0);
      check($sformatf("%s.busy%0d", tag, b), int'(busy), 1);
    end
    step();
    check({tag, ".done"}, int'(done), 1);
    check({tag, ".valid_off"}, int'(out_valid), 0);
    check({tag, ".sat"}, int'(sat_count), v.sat);
    step();
    check({tag, ".done_off"}, int'(done), 0);
    check({tag, ".sat_hold"}, int'(sat_count), v.sat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{5, -3, 127, -128, 0, 5, -3, 127, -128, 0};
    tbl[1] = '{200, -300, 131071, -131072, 0, 127, -128, 127, -128, 4};
    tbl[2] = '{6, -6, 5, -5, 2, 2, -1, 1, -1, 0};
    tbl[3] = '{131071, -131072, 100, -100, 31, 1, -1, 0, 0, 0};
    tbl[4] = '{8, -8, 40000, -40000, 4, 1, 0, 127, -128, 2};

    rst = 1'b1; in_valid = 1'b0; in_acc = '0; in_shift = '0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    check("rst.out_valid", int'(out_valid), 0);
    check("rst.out_last",  int'(out_last), 0);
    check("rst.out_data",  int'(out_data), 0);
    check("rst.done",      int'(done), 0);
    check("rst.busy",      int'(busy), 0);
    check("rst.sat",       int'(sat_count), 0);
    check("rst.in_ready",  int'(in_ready), 1);

    for (int i = 0; i < 5; i++) run_job(tbl[i], $sformatf("job%0d", i));

    // Backpressure after the second beat is presented.
    load(tbl[0]);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("bp.beat0", int'(out_data), 5);
    step();
    check("bp.beat1", int'(out_data), -3);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("bp.hold_data%0d", c), int'(out_data), -3);
      check($sformatf("bp.hold_valid%0d", c), int'(out_valid), 1);
      check($sformatf("bp.hold_last%0d", c), int'(out_last), 0);
    end
    out_ready = 1'b1;
    step();
    check("bp.beat2", int'(out_data), 127);
    step();
    check("bp.beat3", int'(out_data), -128);
    check("bp.last3", int'(out_last), 1);
    step();
    check("bp.done", int'(done), 1);
    step();

    // in_valid held through STREAM and DONE with different data.
    load(tbl[2]);
    in_valid = 1'b1;
    step();
    load(tbl[1]);
    check("hold.beat0", int'(out_data), 2);
    for (int b = 1; b < N; b++) begin
      check($sformatf("hold.in_ready%0d", b), int'(in_ready), 0);
      step();
    end
    check("hold.beat3", int'(out_data), -1);
    step();
    check("hold.done", int'(done), 1);
    check("hold.done_in_ready", int'(in_ready), 0);
    step();
    check("hold.idle_in_ready", int'(in_ready), 1);
    check("hold.idle_valid", int'(out_valid), 0);
    step();
    in_valid = 1'b0;
    check("hold.newjob_beat0", int'(out_data), 127);
    check("hold.newjob_valid", int'(out_valid), 1);
    for (int b = 1; b < N; b++) step();
    check("hold.newjob_beat3", int'(out_data), -128);
    step();
    check("hold.newjob_sat", int'(sat_count), 4);
    step();

    // Reset while the third beat is presented.
    load(tbl[1]);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    check("abort.beat2", int'(out_data), 127);
    check("abort.sat_pre", int'(sat_count), 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort.valid", int'(out_valid), 0);
    check("abort.busy", int'(busy), 0);
    check("abort.in_ready", int'(in_ready), 1);
    check("abort.sat", int'(sat_count), 0);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("abort.no_done%0d", c), int'(done), 0);
      check($sformatf("abort.no_valid%0d", c), int'(out_valid), 0);
      step();
    end
    run_job(tbl[4], "post_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
